m_mem_access: RTL and testbench
===============================

Name: m_mem_access

Overview:
- Memory-stage data-bus access controller: turns a load/store in M stage into one handshaked request on the external data memory port.
- Drives word-aligned address, byte enables and replicated store data; captures read data.
- Stalls the pipeline until the access completes.
- Sits directly upstream of the load data extender: its captured read word and byte address feed the extender, which applies lw/lh/lb selection and sign extension.

Parameters:
- ACK_TIMEOUT, 0: max cycles waiting for mem_ack in BUSY; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; ACK_TIMEOUT must be < 2**CNT_W.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- op_valid  input  1  M-stage instruction valid (not a bubble)
- mem_read  input  1  M-stage instruction is a load
- mem_write  input  1  M-stage instruction is a store
- size  input  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
- addr  input  32  byte address from ALU
- wd  input  32  store data (register rt)
- m_data_addr  output  32  word-aligned address to data memory
- m_data_wdata  output  32  store data, lane-replicated
- m_data_byteen  output  4  write byte enables, 0000 for loads
- mem_req  output  1  request valid
- mem_ack  input  1  memory accepts request and, for loads, presents mem_rdata
- mem_rdata  input  32  read word from memory
- rdata_q  output  32  captured read word, to load extender
- rdata_addr  output  32  byte address of captured access, to load extender
- done  output  1  one-cycle pulse: access finished
- stall  output  1  freeze F/D/E/M pipeline registers
- bus_err  output  1  timeout occurred, valid with done
- exc  output  1  address exception, valid with done
- exc_code  output  5  4 = AdEL, 5 = AdES; 0 otherwise

Behaviour:
- Reset: state IDLE.
- Reset values: mem_req 0, m_data_addr 0, m_data_wdata 0, m_data_byteen 0, rdata_q 0, rdata_addr 0, done 0, bus_err 0, exc 0, exc_code 0, counter 0.
- Reset mid-access drops mem_req on the next edge; no request is reissued.
- access = op_valid & (mem_read | mem_write). If both read and write are asserted, the access is a store and rdata_q is not updated.
- FSM states: IDLE, BUSY, DONE.
- IDLE, on access:
  - register m_data_addr = {addr[31:2], 2'b00} and rdata_addr = addr.
  - byteen for stores: word 1111; half addr[1] ? 1100 : 0011; byte 0001 << addr[1:0].
  - wdata: word wd; half {2{wd[15:0]}}; byte {4{wd[7:0]}}.
  - go to BUSY.
- BUSY:
  - mem_req = 1; outputs held stable.
  - On mem_ack: capture mem_rdata into rdata_q if load, then go to DONE.
  - Counter increments each BUSY cycle without ack.
  - If ACK_TIMEOUT != 0 and the counter reaches ACK_TIMEOUT, go to DONE with bus_err = 1 and rdata_q = 0.
- DONE:
  - done = 1, mem_req = 0, byteen cleared, counter cleared.
  - Next state IDLE unconditionally.
- stall = access & (state != DONE), combinational. Minimum latency is 3 cycles with ack in the first BUSY cycle; the pipeline advances at the end of DONE.
- Non-memory instructions and bubbles never stall and never assert mem_req.
- done, bus_err and exc are single-cycle pulses.

Optional Feature:
- Macro ALIGN_CHECK_EN.
- Defined: misalignment is word with addr[1:0] != 0, or half with addr[0] != 0.
  - IDLE goes directly to DONE, no mem_req.
  - exc = 1 with done; exc_code = 4 for a load, 5 for a store.
  - Store enables are never driven for the faulting access.
- Undefined: addr low bits used only for lane selection; exc and exc_code tied 0.

Test Plan:
- sw: addr 0x1004, wd 0xAABBCCDD, ack in first BUSY cycle -> m_data_addr 0x1004, byteen 1111, wdata 0xAABBCCDD; stall high 2 cycles; done in cycle 3.
- sb: addr 0x2003, wd 0x000000EE -> byteen 1000, wdata 0xEEEEEEEE. sh: addr 0x2002, wd 0x1234 -> byteen 1100, wdata 0x12341234.
- lh: addr 0x3006, ack after 4 wait cycles, mem_rdata 0x8001_7FFF -> rdata_q 0x80017FFF, rdata_addr 0x3006, stall 6 cycles, byteen 0000.
- ACK_TIMEOUT=5, no ack -> mem_req high 5 cycles, then done=1, bus_err=1, rdata_q 0.
- reset asserted in BUSY -> next cycle mem_req 0, stall 0 for a bubble, all outputs at reset values.
- ALIGN_CHECK_EN: lw addr 0x1002 -> no mem_req, done=1, exc=1, exc_code 4. sh addr 0x1001 -> exc_code 5.

Source files
------------

// File: rtl/m_mem_access.sv
// Memory-stage data-bus access controller: one handshaked request per load/store, pipeline stall.
// Optional ALIGN_CHECK_EN macro enables AdEL/AdES detection for misaligned word/half accesses.
module m_mem_access #(
  parameter int unsigned ACK_TIMEOUT = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rdata_q,
  output logic [31:0] rdata_addr,
  output logic        done,
  output logic        stall,
  output logic        bus_err,
  output logic        exc,
  output logic [4:0]  exc_code
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(ACK_TIMEOUT);
  localparam logic [4:0]       ExcAdEL    = 5'd4;
  localparam logic [4:0]       ExcAdES    = 5'd5;

  state_e             state_q, state_d;
  logic [31:0]        maddr_q, maddr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         byteen_q, byteen_d;
  logic [31:0]        rword_q, rword_d;
  logic [31:0]        raddr_q, raddr_d;
  logic               is_load_q, is_load_d;
  logic               err_q, err_d;
  logic               exc_q, exc_d;
  logic [4:0]         code_q, code_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               access;
  logic               is_load;
  logic               misaligned;
  logic [CNT_W-1:0]   cnt_inc;
  logic               timeout_hit;

  // Store byte enables; reserved size 11 behaves as a word.
  function automatic logic [3:0] lane_byteen(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] be;
    unique case (sz)
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b0001 << lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate store data across lanes so memory can pick any lane with byteen alone.
  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    unique case (sz)
      2'b01:   w = {2{d[15:0]}};
      2'b10:   w = {4{d[7:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  assign access  = op_valid & (mem_read | mem_write);
  // A simultaneous read/write is treated as a store.
  assign is_load = mem_read & ~mem_write;

`ifdef ALIGN_CHECK_EN
  assign misaligned = ((size == 2'b01) & addr[0]) |
                      (((size == 2'b00) | (size == 2'b11)) & (addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_inc == TimeoutCnt);

  always_comb begin
    state_d   = state_q;
    maddr_d   = maddr_q;
    wdata_d   = wdata_q;
    byteen_d  = byteen_q;
    rword_d   = rword_q;
    raddr_d   = raddr_q;
    is_load_d = is_load_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    exc_d     = 1'b0;
    code_d    = 5'd0;

    unique case (state_q)
      StIdle: begin
        if (access) begin
          maddr_d   = {addr[31:2], 2'b00};
          raddr_d   = addr;
          wdata_d   = lane_wdata(size, wd);
          is_load_d = is_load;
          cnt_d     = '0;
          if (misaligned) begin
            byteen_d = 4'b0000;
            exc_d    = 1'b1;
            code_d   = is_load ? ExcAdEL : ExcAdES;
            state_d  = StDone;
          end else begin
            byteen_d = mem_write ? lane_byteen(size, addr[1:0]) : 4'b0000;
            state_d  = StBusy;
          end
        end
      end
      StBusy: begin
        if (mem_ack) begin
          if (is_load_q) rword_d = mem_rdata;
          byteen_d = 4'b0000;
          state_d  = StDone;
        end else if (timeout_hit) begin
          err_d    = 1'b1;
          rword_d  = 32'd0;
          byteen_d = 4'b0000;
          cnt_d    = cnt_inc;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      maddr_q   <= 32'd0;
      wdata_q   <= 32'd0;
      byteen_q  <= 4'd0;
      rword_q   <= 32'd0;
      raddr_q   <= 32'd0;
      is_load_q <= 1'b0;
      err_q     <= 1'b0;
      exc_q     <= 1'b0;
      code_q    <= 5'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      maddr_q   <= maddr_d;
      wdata_q   <= wdata_d;
      byteen_q  <= byteen_d;
      rword_q   <= rword_d;
      raddr_q   <= raddr_d;
      is_load_q <= is_load_d;
      err_q     <= err_d;
      exc_q     <= exc_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
    end
  end

  assign m_data_addr   = maddr_q;
  assign m_data_wdata  = wdata_q;
  assign m_data_byteen = byteen_q;
  assign rdata_q       = rword_q;
  assign rdata_addr    = raddr_q;
  assign mem_req       = (state_q == StBusy);
  assign done          = (state_q == StDone);
  assign bus_err       = err_q;
  assign exc           = exc_q;
  assign exc_code      = code_q;
  // Release the pipeline during DONE so it advances at the end of that cycle.
  assign stall         = access & (state_q != StDone);

endmodule

// File: tb/tb_m_mem_access.sv
// Directed, table-driven bench for m_mem_access (built with ACK_TIMEOUT = 5).
module tb_m_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, mem_read, mem_write;
  logic [1:0]  size;
  logic [31:0] addr, wd;
  logic [31:0] m_data_addr, m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic        mem_req, mem_ack;
  logic [31:0] mem_rdata, rdata_q, rdata_addr;
  logic        done, stall, bus_err, exc;
  logic [4:0]  exc_code;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  m_mem_access #(
    .ACK_TIMEOUT(5),
    .CNT_W      (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .op_valid     (op_valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .size         (size),
    .addr         (addr),
    .wd           (wd),
    .m_data_addr  (m_data_addr),
    .m_data_wdata (m_data_wdata),
    .m_data_byteen(m_data_byteen),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .rdata_q      (rdata_q),
    .rdata_addr   (rdata_addr),
    .done         (done),
    .stall        (stall),
    .bus_err      (bus_err),
    .exc          (exc),
    .exc_code     (exc_code)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    int          waits;   // BUSY cycles before ack; large means never
    logic [31:0] rdat;
    int          e_busy;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_err;
    logic        e_exc;
    logic [4:0]  e_code;
    logic        chk_rd;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic [31:0] a, input logic [31:0] d, input int waits,
                              input logic [31:0] rdat, input int e_busy,
                              input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wdata, input logic e_err,
                              input logic e_exc, input logic [4:0] e_code,
                              input logic chk_rd, input logic [31:0] e_rdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sz = sz; v.a = a; v.d = d; v.waits = waits; v.rdat = rdat;
    v.e_busy = e_busy; v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata;
    v.e_err = e_err; v.e_exc = e_exc; v.e_code = e_code; v.chk_rd = chk_rd;
    v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    op_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'b00;
    addr = 32'd0; wd = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".m_data_addr"}, m_data_addr, 32'd0);
    check({tag, ".m_data_wdata"}, m_data_wdata, 32'd0);
    check({tag, ".byteen"}, {28'd0, m_data_byteen}, 32'd0);
    check({tag, ".rdata_q"}, rdata_q, 32'd0);
    check({tag, ".rdata_addr"}, rdata_addr, 32'd0);
    check({tag, ".ctl"}, {27'd0, mem_req, done, stall, bus_err, exc}, 32'd0);
    check({tag, ".exc_code"}, {27'd0, exc_code}, 32'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int    stalls = 0;
    int    busy   = 0;
    bit    fin    = 1'b0;
    string t      = $sformatf("v%0d", idx);
    @(posedge clk); #1;
    op_valid = 1'b1; mem_read = v.rd; mem_write = v.wr; size = v.sz;
    addr = v.a; wd = v.d; mem_rdata = v.rdat; mem_ack = 1'b0;
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      mem_ack = mem_req && (busy == v.waits);
      @(negedge clk);
      if (stall) stalls++;
      if (mem_req) begin
        if (busy == 0) begin
          check({t, ".m_data_addr"}, m_data_addr, v.e_addr);
          check({t, ".byteen"}, {28'd0, m_data_byteen}, {28'd0, v.e_be});
          check({t, ".wdata"}, m_data_wdata, v.e_wdata);
        end
        busy++;
      end
      if (done) begin
        fin = 1'b1;
        check({t, ".busy_cycles"}, busy, v.e_busy);
        check({t, ".stall_cycles"}, stalls, v.e_busy + 1);
        check({t, ".bus_err"}, {31'd0, bus_err}, {31'd0, v.e_err});
        check({t, ".exc"}, {31'd0, exc}, {31'd0, v.e_exc});
        check({t, ".exc_code"}, {27'd0, exc_code}, {27'd0, v.e_code});
        check({t, ".done_byteen"}, {28'd0, m_data_byteen}, 32'd0);
        check({t, ".rdata_addr"}, rdata_addr, v.a);
        if (v.chk_rd) check({t, ".rdata_q"}, rdata_q, v.e_rdata);
      end
      @(posedge clk); #1;
    end
    check({t, ".done_seen"}, {31'd0, fin}, 32'd1);
    // done must be a single-cycle pulse
    check({t, ".done_pulse"}, {30'd0, done, bus_err}, 32'd0);
    idle_inputs();
  endtask

  initial begin
    vecs[0]  = mk(0, 1, 2'd0, 32'h1004, 32'hAABBCCDD, 0, 0, 1, 32'h1004, 4'hF,
                  32'hAABBCCDD, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 2'd2, 32'h2003, 32'h000000EE, 0, 0, 1, 32'h2000, 4'h8,
                  32'hEEEEEEEE, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 2'd1, 32'h2002, 32'h00001234, 0, 0, 1, 32'h2000, 4'hC,
                  32'h12341234, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 0, 2'd1, 32'h3006, 0, 4, 32'h80017FFF, 5, 32'h3004, 4'h0,
                  0, 0, 0, 0, 1, 32'h80017FFF);
    vecs[4]  = mk(1, 0, 2'd0, 32'h1008, 0, 1, 32'hDEADBEEF, 2, 32'h1008, 4'h0,
                  0, 0, 0, 0, 1, 32'hDEADBEEF);
    vecs[5]  = mk(0, 1, 2'd2, 32'h2001, 32'h0000005A, 0, 0, 1, 32'h2000, 4'h2,
                  32'h5A5A5A5A, 0, 0, 0, 1, 32'hDEADBEEF);
    vecs[6]  = mk(0, 1, 2'd1, 32'h2000, 32'hFFFFABCD, 0, 0, 1, 32'h2000, 4'h3,
                  32'hABCDABCD, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 2'd3, 32'h0040, 32'h11223344, 2, 0, 3, 32'h0040, 4'hF,
                  32'h11223344, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 1, 2'd0, 32'h0050, 32'hCAFEF00D, 0, 32'h12345678, 1, 32'h0050, 4'hF,
                  32'hCAFEF00D, 0, 0, 0, 1, 32'hDEADBEEF);
    vecs[9]  = mk(1, 0, 2'd0, 32'h0060, 0, 99, 32'hFFFFFFFF, 5, 32'h0060, 4'h0,
                  0, 1, 0, 0, 1, 32'h0);
    vecs[10] = mk(1, 0, 2'd2, 32'h0003, 0, 0, 32'h00000011, 1, 32'h0000, 4'h0,
                  0, 0, 0, 0, 1, 32'h00000011);
`ifdef ALIGN_CHECK_EN
    vecs[11] = mk(1, 0, 2'd0, 32'h1002, 0, 0, 32'h00000077, 0, 32'h1000, 4'h0,
                  0, 0, 1, 5'd4, 1, 32'h00000011);
    vecs[12] = mk(0, 1, 2'd1, 32'h1001, 32'h0000BEEF, 0, 0, 0, 32'h1000, 4'h0,
                  0, 0, 1, 5'd5, 0, 0);
`else
    vecs[11] = mk(1, 0, 2'd0, 32'h1002, 0, 0, 32'h00000077, 1, 32'h1000, 4'h0,
                  0, 0, 0, 0, 1, 32'h00000077);
    vecs[12] = mk(0, 1, 2'd1, 32'h1001, 32'h0000BEEF, 0, 0, 1, 32'h1000, 4'h3,
                  32'hBEEFBEEF, 0, 0, 0, 0, 0);
`endif

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Bubble with mem_read set, then a valid non-memory instruction: no stall, no request.
    @(posedge clk); #1;
    op_valid = 1'b0; mem_read = 1'b1; addr = 32'h0100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bubble%0d", k), {30'd0, stall, mem_req}, 32'd0);
    end
    @(posedge clk); #1;
    op_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("nonmem%0d", k), {30'd0, stall, mem_req}, 32'd0);
    end
    idle_inputs();

    // Reset while BUSY: request drops on the next edge and nothing is reissued.
    @(posedge clk); #1;
    op_valid = 1'b1; mem_read = 1'b1; size = 2'b00; addr = 32'h0080;
    @(posedge clk); #1;
    @(negedge clk);
    check("busy_before_reset", {31'd0, mem_req}, 32'd1);
    reset = 1'b1; op_valid = 1'b0; mem_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(negedge clk);
    check("no_reissue", {31'd0, mem_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
